// File: rtl/t10_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling; rx_ready one cycle after stop sample.
// No backpressure: each good frame overwrites rx_byte; a low stop bit pulses framing_err and waits for idle line.
module t10_uart_rx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       framing_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_m;
  logic             rx_s;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_byte     <= '0;
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              rx_byte  <= shift;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line is not a new start bit; only a return high re-arms
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_t10_uart_rx.sv
// Directed bench for t10_uart_rx: frame table plus glitch, back-to-back, reset and baud-skew sequences.
module tb_t10_uart_rx;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx_sm = 1'b1;
  logic       rx_big = 1'b1;
  logic [7:0] rx_byte, rx_byte_big;
  logic       rx_ready, framing_err, busy;
  logic       rx_ready_big, framing_err_big, busy_big;

  always #5 clk = ~clk;

  t10_uart_rx #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .nRst(nRst), .rx_serial(rx_sm),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .framing_err(framing_err), .busy(busy)
  );

  t10_uart_rx #(.CLKS_PER_BIT(1042)) dut_big (
    .clk(clk), .nRst(nRst), .rx_serial(rx_big),
    .rx_byte(rx_byte_big), .rx_ready(rx_ready_big), .framing_err(framing_err_big), .busy(busy_big)
  );

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
  int rdy_big_cnt = 0, err_big_cnt = 0;
  logic [7:0] byte_q[$];

  always @(negedge clk) begin
    if (rx_ready) begin
      rdy_cnt++;
      byte_q.push_back(rx_byte);
    end
    if (framing_err) err_cnt++;
    if (rx_ready && framing_err) both_cnt++;
    if (rx_ready_big) rdy_big_cnt++;
    if (framing_err_big) err_big_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int cycles, input bit big);
    if (big) rx_big = v;
    else     rx_sm = v;
    repeat (cycles) @(posedge clk);
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held for stop_len cycles
  task automatic send(input logic [7:0] data, input logic stop, input int per,
                      input int stop_len, input bit big);
    drive(1'b0, per, big);
    for (int i = 0; i < 8; i++) drive(data[i], per, big);
    drive(stop, stop_len, big);
  endtask

  task automatic idle(input int cycles);
    rx_sm = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    int         stop_len;
    logic [7:0] exp_byte;
    int         exp_rdy;
    int         exp_err;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int r0, e0;

    vecs[0] = '{"good_a5",  8'hA5, 1'b1, 8,  8'hA5, 1, 0};
    vecs[1] = '{"stop0_3c", 8'h3C, 1'b0, 20, 8'hA5, 0, 1};
    vecs[2] = '{"good_81",  8'h81, 1'b1, 8,  8'h81, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_framing_err", framing_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    nRst = 1'b1;
    idle(4);

    for (int i = 0; i < 3; i++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      @(posedge clk);
      send(vecs[i].data, vecs[i].stop, 8, vecs[i].stop_len, 1'b0);
      idle(6);
      check({vecs[i].name, "_byte"}, rx_byte, vecs[i].exp_byte);
      check({vecs[i].name, "_rdy"}, rdy_cnt - r0, vecs[i].exp_rdy);
      check({vecs[i].name, "_err"}, err_cnt - e0, vecs[i].exp_err);
      check({vecs[i].name, "_busy"}, busy, 0);
    end

    // Short low glitch aborts at the half-bit check
    r0 = rdy_cnt;
    e0 = err_cnt;
    @(posedge clk);
    rx_sm = 1'b0;
    repeat (2) @(posedge clk);
    rx_sm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    check("glitch_rdy", rdy_cnt - r0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_byte", rx_byte, 8'h81);

    // Back-to-back frames without idle gap
    byte_q.delete();
    e0 = err_cnt;
    @(posedge clk);
    send(8'h00, 1'b1, 8, 8, 1'b0);
    send(8'hFF, 1'b1, 8, 8, 1'b0);
    idle(6);
    check("b2b_count", byte_q.size(), 2);
    if (byte_q.size() == 2) begin
      check("b2b_first", byte_q[0], 8'h00);
      check("b2b_second", byte_q[1], 8'hFF);
    end
    check("b2b_err", err_cnt - e0, 0);

    // Reset during data bit 4 of 0x5A
    r0 = rdy_cnt;
    @(posedge clk);
    drive(1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) drive(r0 >= 0 ? ((8'h5A >> i) & 8'h01) != 0 : 1'b0, 8, 1'b0);
    drive(1'b1, 3, 1'b0);
    #2 nRst = 1'b0;
    @(negedge clk);
    check("midrst_byte", rx_byte, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #2 nRst = 1'b1;
    idle(20);
    check("midrst_rdy", rdy_cnt - r0, 0);
    check("midrst_byte_after", rx_byte, 0);
    @(posedge clk);
    send(8'hC3, 1'b1, 8, 8, 1'b0);
    idle(6);
    check("post_rst_byte", rx_byte, 8'hC3);
    check("post_rst_rdy", rdy_cnt - r0, 1);

    // Full-rate instance with a 2% slow transmitter
    @(posedge clk);
    send(8'h37, 1'b1, 1063, 1063, 1'b1);
    rx_big = 1'b1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check("skew_byte", rx_byte_big, 8'h37);
    check("skew_rdy", rdy_big_cnt, 1);
    check("skew_err", err_big_cnt, 0);
    check("skew_busy", busy_big, 0);

    check("ready_err_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
